// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: instruction/address width, NOP encoding,
// default reset vector and the fetch-buffer entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular FIFO of
// {instr, pc} with synchronous push/pop, a flush that empties it, and an
// occupancy count. Entry width follows riscv_pkg::XLEN.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_instr,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     pop,
  output logic [XLEN-1:0]          head_instr,
  output logic [XLEN-1:0]          head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t          mem_q [DEPTH];
  fetch_entry_t          wr_entry;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  // Pointer and occupancy next-state; flush wins over any push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_entry = '{instr: push_instr, pc: push_pc};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read once count says it was written
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is presented combinationally
  always_comb begin
    head_instr = mem_q[rd_ptr_q].instr;
    head_pc    = mem_q[rd_ptr_q].pc;
    count      = count_q;
  end

  // The fetch stage's request throttling must make these impossible
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count_q == CntW'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request per cycle to a fixed-latency
// (one cycle) instruction memory, buffers responses, and hands them to decode.
// Redirects flush the buffer and bump an epoch so stale responses are dropped.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_D,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCtarget_E,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCplus4_D,
  output logic             valid_D
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic             inflight_epoch_q, inflight_epoch_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic             epoch_q, epoch_d;

  logic             pop;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CntW-1:0]  count;
  logic [OccW-1:0]  occupancy;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (PCsrc_E),
    .push       (fifo_push),
    .push_instr (imem_rdata),
    .push_pc    (inflight_pc_q),
    .pop        (fifo_pop),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  // Request throttling, PC/epoch next-state and decode-side outputs
  always_comb begin
    valid_D   = (count != '0);
    instr_D   = valid_D ? head_instr : WIDTH'(NOP_INSTR);
    PC_D      = valid_D ? head_pc : '0;
    PCplus4_D = PC_D + WIDTH'(4);
    imem_addr = pc_q;

    pop = valid_D && !stall_D;
    // Slots already claimed after this edge: buffered + returning - leaving
    occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
    imem_req  = !rst && !PCsrc_E && (occupancy < OccW'(DEPTH));

    // A redirect discards whatever arrives or leaves on its edge
    fifo_push = inflight_q && (inflight_epoch_q == epoch_q) && !PCsrc_E;
    fifo_pop  = pop && !PCsrc_E;

    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = imem_req;
    inflight_epoch_d = epoch_q;
    inflight_pc_d    = inflight_pc_q;
    if (PCsrc_E) begin
      pc_d    = {PCtarget_E[WIDTH-1:2], 2'b00};
      epoch_d = !epoch_q;
    end else if (imem_req) begin
      pc_d          = pc_q + WIDTH'(4);
      inflight_pc_d = pc_q;
    end
  end

  // Fetch state with asynchronous reset; clearing inflight drops any old response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
      epoch_q          <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
      epoch_q          <= epoch_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (power of two, >=2).
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have stall_D  input  1  decode cannot accept this cycle.
REQ-007 SHALL have PCsrc_E  input  1  taken branch/jump redirect.
REQ-008 SHALL have PCtarget_E  input  WIDTH  redirect target address.
REQ-009 SHALL have imem_req  output  1  fetch request this cycle.
REQ-010 SHALL have imem_addr  output  WIDTH  fetch address, equal to PC.
REQ-011 SHALL have imem_rdata  input  WIDTH  instruction word, valid exactly one cycle after an accepted request.
REQ-012 SHALL have instr_D  output  WIDTH  instruction presented to decode.
REQ-013 SHALL have PC_D  output  WIDTH  address of instr_D.
REQ-014 SHALL have PCplus4_D  output  WIDTH  PC_D + 4, modulo 2^WIDTH.
REQ-015 SHALL have valid_D  output  1  instr_D/PC_D hold a real instruction.

Function
REQ-016 SHALL keep PC, an in-flight flag, an epoch bit and a DEPTH-entry FIFO of {instr, pc}.
REQ-017 SHALL drive imem_req = 1 when !rst and (count + inflight - pop) < DEPTH, where pop = valid_D & !stall_D.
REQ-018 SHALL, on a clock edge with imem_req = 1, advance PC by 4 (wrap at 2^WIDTH) and set inflight with the current epoch and the request PC.
REQ-019 SHALL, on the edge after a request, push {imem_rdata, request PC} into the FIFO if the tagged epoch equals the current epoch, and otherwise discard it.
REQ-020 SHALL present the FIFO head combinationally on instr_D/PC_D; valid_D = (count != 0).
REQ-021 SHALL drive instr_D = 32'h0000_0013 (NOP) and PC_D = 0 when valid_D = 0.
REQ-022 SHALL pop the head on an edge where valid_D = 1 and stall_D = 0; push and pop on the same edge SHALL leave count unchanged.
REQ-023 SHALL hold instr_D, PC_D and valid_D stable while stall_D = 1.
REQ-024 SHALL, when PCsrc_E = 1, on that edge: load PC <= PCtarget_E, empty the FIFO, toggle the epoch, and ignore any concurrent push or pop.
REQ-025 SHALL give PCsrc_E priority over stall_D and over a full FIFO.
REQ-026 SHALL drive imem_req = 0 in the redirect cycle; fetching from PCtarget_E SHALL start the next cycle.
REQ-027 SHALL sustain one instruction per cycle with stall_D = 0: first valid_D 2 cycles after the first request, or after a redirect request.
REQ-028 SHALL never overflow or underflow: push on full and pop on empty are unreachable and SHALL be assertion-checked.
REQ-029 SHALL force PCtarget_E[1:0] to 2'b00 when loading PC.

Reset
REQ-030 SHALL, on rst asserting, asynchronously set PC = RESET_PC, count = 0, inflight = 0, epoch = 0, valid_D = 0, and instr_D = NOP.
REQ-031 SHALL hold imem_req = 0 while rst = 1.
REQ-032 SHALL drop a response to a request issued before a mid-operation reset.

Structure
REQ-033 SHALL place the NOP encoding, the RESET_PC default and the {instr, pc} entry typedef in shared package riscv_pkg.
REQ-034 SHALL implement the buffer as one sub-module, fetch_fifo (synchronous push/pop, async reset, count output).

Verification
REQ-035 SHALL cover reset release with stall_D = 0 and memory returning addr+0x100: PC_D = 0,4,8 on consecutive cycles from cycle 2, and instr_D = 0x100,0x104,0x108.
REQ-036 SHALL cover stall_D = 1 for 3 cycles at PC_D = 8: outputs are held, imem_req drops once the FIFO is full, and the sequence resumes 8,C,10 with no loss or duplication.
REQ-037 SHALL cover PCsrc_E = 1 with PCtarget_E = 0x40 while a fetch of 0x10 is in flight: the 0x10 response is discarded, valid_D = 0 for 2 cycles, then PC_D = 0x40.
REQ-038 SHALL cover PCsrc_E = 1 with stall_D = 1 and a full FIFO: the redirect still takes effect and the next valid PC_D = target.
REQ-039 SHALL cover PC = 0xFFFF_FFFC: the next fetch address is 0x0000_0000 and PCplus4_D wraps to 0.
REQ-040 SHALL cover rst asserted mid-stream with a request in flight: valid_D = 0 immediately, and after release the first PC_D = RESET_PC.
